// File: rtl/hsv_to_rgb_pipe_pkg.sv
// -----------------------------------------------------------------------------
// colour_pkg
// Shared definitions for the HSV-to-RGB converter:
//   - hue sextant constants and the compare-chain thresholds
//   - region_e, the 3-bit colour-wheel sextant index
//   - quantise(), 8-bit channel to W-bit channel scaling
// Configuration macro: HSV_TO_RGB_ROUND_EN
//   undefined : quantise truncates,        c*(2^W-1)/255
//   defined   : quantise rounds to nearest, (c*(2^W-1)+127)/255
// -----------------------------------------------------------------------------
package colour_pkg;

    localparam int unsigned HUE_SEXTANT = 43;
    localparam int unsigned REM_SCALE   = 6;
    localparam int unsigned N_THRESH    = 5;

    // Entry i is the lowest hue of region i+1 (multiples of HUE_SEXTANT).
    localparam logic [N_THRESH-1:0][7:0] SEXTANT_THRESH = {
        8'd215, 8'd172, 8'd129, 8'd86, 8'd43
    };

    typedef enum logic [2:0] {
        REGION_0 = 3'd0,
        REGION_1 = 3'd1,
        REGION_2 = 3'd2,
        REGION_3 = 3'd3,
        REGION_4 = 3'd4,
        REGION_5 = 3'd5
    } region_e;

    // Scale an 8-bit channel to w bits (w in 1..8). The divisor is a
    // constant, so this reduces to a multiply by a constant reciprocal.
    function automatic logic [7:0] quantise(input logic [7:0] c, input int unsigned w);
        logic [15:0] scale;
        logic [15:0] prod;
        scale = 16'((32'd1 << w) - 32'd1);
        prod  = 16'(c) * scale;
`ifdef HSV_TO_RGB_ROUND_EN
        prod  = prod + 16'd127;
`endif
        return 8'(prod / 16'd255);
    endfunction

endpackage

// File: rtl/hsv_to_rgb_pipe_if.sv
// -----------------------------------------------------------------------------
// hsv_to_rgb_pipe_if
// Pixel stream bundle for hsv_to_rgb_pipe: HSV input stream with user
// sideband, packed-RGB output stream with aligned sideband.
//   slave  : converter side (accepts HSV, produces RGB)
//   master : environment side (produces HSV, consumes RGB)
// Parameters: RGB_W (R_W+G_W+B_W of the converter), USER_W (sideband width).
// -----------------------------------------------------------------------------
interface hsv_to_rgb_pipe_if #(
    parameter int unsigned RGB_W  = 16,
    parameter int unsigned USER_W = 17
) ();

    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_h;
    logic [7:0]        in_s;
    logic [7:0]        in_v;
    logic [USER_W-1:0] in_user;
    logic              out_valid;
    logic              out_ready;
    logic [RGB_W-1:0]  out_rgb;
    logic [USER_W-1:0] out_user;

    modport slave (
        input  in_valid, in_h, in_s, in_v, in_user, out_ready,
        output in_ready, out_valid, out_rgb, out_user
    );

    modport master (
        output in_valid, in_h, in_s, in_v, in_user, out_ready,
        input  in_ready, out_valid, out_rgb, out_user
    );

endinterface

// File: rtl/hsv_stage_ctl.sv
// -----------------------------------------------------------------------------
// hsv_stage_ctl
// Valid-bit shift register and stall control for a lock-step pipeline.
// All stages advance together when the last stage is empty or being drained.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   in_valid      valid of the pixel offered to stage 1
//   out_ready     downstream accepts the last stage
//   advance       every stage loads this cycle
//   in_ready      upstream handshake ready (same as advance)
//   stage_valid   per-stage valid, [0] = first stage, [STAGES-1] = output
// -----------------------------------------------------------------------------
module hsv_stage_ctl #(
    parameter int unsigned STAGES = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              out_ready,
    output logic              advance,
    output logic              in_ready,
    output logic [STAGES-1:0] stage_valid
);

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;

    always_comb begin
        advance = !valid_q[STAGES-1] || out_ready;
        valid_d = valid_q;
        if (advance) begin
            valid_d = {valid_q[STAGES-2:0], in_valid};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign in_ready    = advance;
    assign stage_valid = valid_q;

endmodule

// File: rtl/hsv_to_rgb_pipe.sv
// -----------------------------------------------------------------------------
// hsv_to_rgb_pipe
// Three-stage pipelined HSV-to-RGB converter with user sideband and
// valid/ready flow control. Latency 3 cycles, throughput 1 pixel/clk.
//   stage 1: hue sextant split (region, scaled remainder), register s/v/user
//   stage 2: P/Q/T intermediates (16-bit products, >>8)
//   stage 3: channel select per region, grey bypass, quantise to R_W/G_W/B_W
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    hsv_to_rgb_pipe_if.slave: in_valid/in_ready/in_h/in_s/in_v/in_user,
//          out_valid/out_ready/out_rgb ({r,g,b}, red in MSBs)/out_user
// Parameters: R_W, G_W, B_W (1..8), USER_W (>=1, must match the interface).
// Configuration macro: HSV_TO_RGB_ROUND_EN selects round-to-nearest
// quantisation (see colour_pkg); default truncates.
// -----------------------------------------------------------------------------
module hsv_to_rgb_pipe
    import colour_pkg::*;
#(
    parameter int unsigned R_W    = 5,
    parameter int unsigned G_W    = 6,
    parameter int unsigned B_W    = 5,
    parameter int unsigned USER_W = 17
) (
    input logic                 clk,
    input logic                 reset,
    hsv_to_rgb_pipe_if.slave    bus
);

    localparam int unsigned RGB_W = R_W + G_W + B_W;

    logic       advance;
    logic       in_ready_w;
    logic [2:0] stage_valid;

    hsv_stage_ctl #(
        .STAGES (3)
    ) u_stage_ctl (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (bus.in_valid),
        .out_ready   (bus.out_ready),
        .advance     (advance),
        .in_ready    (in_ready_w),
        .stage_valid (stage_valid)
    );

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = stage_valid[2];

    // ---------------- stage 1: sextant split ----------------
    region_e           region1_q, region1_d;
    logic [7:0]        rem1_q,    rem1_d;
    logic [7:0]        s1_q,      s1_d;
    logic [7:0]        v1_q,      v1_d;
    logic [USER_W-1:0] user1_q,   user1_d;

    region_e    region_c;
    logic [7:0] base_c;

    always_comb begin
        region_c = REGION_0;
        base_c   = '0;
        // Thresholds ascend, so the last one passed wins.
        for (int unsigned i = 0; i < N_THRESH; i++) begin
            if (bus.in_h >= SEXTANT_THRESH[i]) begin
                region_c = region_e'(3'(i + 1));
                base_c   = SEXTANT_THRESH[i];
            end
        end

        region1_d = region1_q;
        rem1_d    = rem1_q;
        s1_d      = s1_q;
        v1_d      = v1_q;
        user1_d   = user1_q;
        if (advance) begin
            region1_d = region_c;
            rem1_d    = 8'((bus.in_h - base_c) * REM_SCALE);
            s1_d      = bus.in_s;
            v1_d      = bus.in_v;
            user1_d   = bus.in_user;
        end
    end

    // ---------------- stage 2: intermediates ----------------
    region_e           region2_q, region2_d;
    logic [7:0]        p2_q,      p2_d;
    logic [7:0]        q2_q,      q2_d;
    logic [7:0]        t2_q,      t2_d;
    logic [7:0]        v2_q,      v2_d;
    logic              grey2_q,   grey2_d;
    logic [USER_W-1:0] user2_q,   user2_d;

    logic [15:0] s_rem_c;
    logic [15:0] s_nrem_c;
    logic [15:0] p_prod_c;
    logic [15:0] q_prod_c;
    logic [15:0] t_prod_c;

    always_comb begin
        s_rem_c  = 16'(s1_q) * 16'(rem1_q);
        s_nrem_c = 16'(s1_q) * 16'(8'd255 - rem1_q);
        p_prod_c = 16'(v1_q) * 16'(8'd255 - s1_q);
        q_prod_c = 16'(v1_q) * 16'(8'd255 - 8'(s_rem_c >> 8));
        t_prod_c = 16'(v1_q) * 16'(8'd255 - 8'(s_nrem_c >> 8));

        region2_d = region2_q;
        p2_d      = p2_q;
        q2_d      = q2_q;
        t2_d      = t2_q;
        v2_d      = v2_q;
        grey2_d   = grey2_q;
        user2_d   = user2_q;
        if (advance) begin
            region2_d = region1_q;
            p2_d      = 8'(p_prod_c >> 8);
            q2_d      = 8'(q_prod_c >> 8);
            t2_d      = 8'(t_prod_c >> 8);
            v2_d      = v1_q;
            grey2_d   = (s1_q == 8'd0);
            user2_d   = user1_q;
        end
    end

    // ---------------- stage 3: select and quantise ----------------
    logic [RGB_W-1:0]  rgb3_q,  rgb3_d;
    logic [USER_W-1:0] user3_q, user3_d;

    logic [7:0]     r8_c, g8_c, b8_c;
    logic [R_W-1:0] rq_c;
    logic [G_W-1:0] gq_c;
    logic [B_W-1:0] bq_c;

    always_comb begin
        unique case (region2_q)
            REGION_0: begin r8_c = v2_q; g8_c = t2_q; b8_c = p2_q; end
            REGION_1: begin r8_c = q2_q; g8_c = v2_q; b8_c = p2_q; end
            REGION_2: begin r8_c = p2_q; g8_c = v2_q; b8_c = t2_q; end
            REGION_3: begin r8_c = p2_q; g8_c = q2_q; b8_c = v2_q; end
            REGION_4: begin r8_c = t2_q; g8_c = p2_q; b8_c = v2_q; end
            REGION_5: begin r8_c = v2_q; g8_c = p2_q; b8_c = q2_q; end
            default:  begin r8_c = v2_q; g8_c = v2_q; b8_c = v2_q; end
        endcase

        // Zero saturation must reproduce v exactly; P would lose 1/256.
        if (grey2_q) begin
            r8_c = v2_q;
            g8_c = v2_q;
            b8_c = v2_q;
        end

        rq_c = R_W'(quantise(r8_c, R_W));
        gq_c = G_W'(quantise(g8_c, G_W));
        bq_c = B_W'(quantise(b8_c, B_W));

        rgb3_d  = rgb3_q;
        user3_d = user3_q;
        if (advance) begin
            rgb3_d  = {rq_c, gq_c, bq_c};
            user3_d = user2_q;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            region1_q <= REGION_0;
            rem1_q    <= '0;
            s1_q      <= '0;
            v1_q      <= '0;
            user1_q   <= '0;
            region2_q <= REGION_0;
            p2_q      <= '0;
            q2_q      <= '0;
            t2_q      <= '0;
            v2_q      <= '0;
            grey2_q   <= 1'b0;
            user2_q   <= '0;
            rgb3_q    <= '0;
            user3_q   <= '0;
        end else begin
            region1_q <= region1_d;
            rem1_q    <= rem1_d;
            s1_q      <= s1_d;
            v1_q      <= v1_d;
            user1_q   <= user1_d;
            region2_q <= region2_d;
            p2_q      <= p2_d;
            q2_q      <= q2_d;
            t2_q      <= t2_d;
            v2_q      <= v2_d;
            grey2_q   <= grey2_d;
            user2_q   <= user2_d;
            rgb3_q    <= rgb3_d;
            user3_q   <= user3_d;
        end
    end

    assign bus.out_rgb  = rgb3_q;
    assign bus.out_user = user3_q;

endmodule

// File: tb/tb_hsv_to_rgb_pipe.sv
// -----------------------------------------------------------------------------
// tb_hsv_to_rgb_pipe
// Scoreboard bench for hsv_to_rgb_pipe at default parameters (RGB565, 17-bit
// user). Expected pixels are queued at the input handshake and compared in
// order at the output handshake. Honours HSV_TO_RGB_ROUND_EN.
// -----------------------------------------------------------------------------
module tb_hsv_to_rgb_pipe;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    hsv_to_rgb_pipe_if #(.RGB_W(16), .USER_W(17)) bus ();

    hsv_to_rgb_pipe #(
        .R_W    (5),
        .G_W    (6),
        .B_W    (5),
        .USER_W (17)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned assert_cnt = 0;
    int unsigned fail_cnt   = 0;
    int unsigned cyc        = 0;
    bit          lat_chk    = 1'b0;
    bit          rand_rdy   = 1'b0;

    typedef struct {
        logic [15:0] rgb;
        logic [16:0] user;
        int unsigned t;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

`ifdef HSV_TO_RGB_ROUND_EN
    localparam logic [15:0] GREY128 = 16'h8410;
    localparam logic [15:0] HUE255  = 16'hF802;
`else
    localparam logic [15:0] GREY128 = 16'h7BEF;
    localparam logic [15:0] HUE255  = 16'hF801;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        assert_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int quant(input int c, input int w);
`ifdef HSV_TO_RGB_ROUND_EN
        return (c * ((1 << w) - 1) + 127) / 255;
`else
        return (c * ((1 << w) - 1)) / 255;
`endif
    endfunction

    function automatic logic [15:0] ref_rgb(input int h, input int s, input int v);
        int region, rem, p, q, t, r, g, b;
        region = h / 43;
        rem    = (h - 43 * region) * 6;
        p      = (v * (255 - s)) / 256;
        q      = (v * (255 - (s * rem) / 256)) / 256;
        t      = (v * (255 - (s * (255 - rem)) / 256)) / 256;
        case (region)
            0:       begin r = v; g = t; b = p; end
            1:       begin r = q; g = v; b = p; end
            2:       begin r = p; g = v; b = t; end
            3:       begin r = p; g = q; b = v; end
            4:       begin r = t; g = p; b = v; end
            default: begin r = v; g = p; b = q; end
        endcase
        if (s == 0) begin
            r = v; g = v; b = v;
        end
        return 16'((quant(r, 5) << 11) | (quant(g, 6) << 5) | quant(b, 5));
    endfunction

    // Output side: pop and compare at every output handshake.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out", 32'(sb.size()), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                check("rgb", 32'(bus.out_rgb), 32'(mon_e.rgb));
                check("user", 32'(bus.out_user), 32'(mon_e.user));
                if (lat_chk) check("latency", cyc - mon_e.t, 32'd3);
            end
        end
    end

    // Random downstream ready.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) bus.out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // Offer one pixel; queue its expected result at the handshake.
    task automatic send(input int h, input int s, input int v, input int user,
                        input logic [15:0] exp_rgb);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_h     = 8'(h);
        bus.in_s     = 8'(s);
        bus.in_v     = 8'(v);
        bus.in_user  = 17'(user);
        forever begin
            @(negedge clk);
            if (bus.in_ready && !reset) begin
                sb.push_back('{exp_rgb, 17'(user), cyc});
                break;
            end
            n++;
            if (n >= 1000) begin
                check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    logic [15:0] held_rgb;
    logic [16:0] held_user;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_h      = '0;
        bus.in_s      = '0;
        bus.in_v      = '0;
        bus.in_user   = '0;
        bus.out_ready = 1'b1;
        reset         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_rgb",   32'(bus.out_rgb),   32'd0);
        check("rst_out_user",  32'(bus.out_user),  32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);

        // Primaries and boundaries, latency checked.
        lat_chk = 1'b1;
        send(0,   255, 255, 1, 16'hF800);
        send(86,  255, 255, 2, 16'h07E0);
        send(172, 255, 255, 3, 16'h001F);
        drain();
        send(99,  0,   128, 4, GREY128);
        send(99,  0,   0,   5, 16'h0000);
        send(255, 255, 255, 6, HUE255);
        drain();

        // Full hue sweep back-to-back.
        for (int i = 0; i < 256; i++) send(i, 255, 255, i, ref_rgb(i, 255, 255));
        drain();

        // Backpressure: fill the pipe with the output stalled.
        lat_chk = 1'b0;
        bus.out_ready = 1'b0;
        send(20,  200, 180, 101, ref_rgb(20,  200, 180));
        send(140, 90,  250, 102, ref_rgb(140, 90,  250));
        send(230, 255, 60,  103, ref_rgb(230, 255, 60));
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        check("bp_held", 32'(sb.size()), 32'd3);
        held_rgb  = bus.out_rgb;
        held_user = bus.out_user;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_rgb_stable",  32'(bus.out_rgb),  32'(held_rgb));
            check("bp_user_stable", 32'(bus.out_user), 32'(held_user));
            check("bp_valid_held",  32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        drain();

        // Random traffic with random gaps and random ready.
        rand_rdy = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            int h, s, v;
            h = $urandom_range(0, 255);
            s = $urandom_range(0, 255);
            v = $urandom_range(0, 255);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(h, s, v, 1000 + i, ref_rgb(h, s, v));
        end
        drain();
        rand_rdy = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset with three pixels in flight.
        bus.out_ready = 1'b0;
        send(10,  255, 255, 201, ref_rgb(10,  255, 255));
        send(50,  255, 255, 202, ref_rgb(50,  255, 255));
        send(200, 255, 255, 203, ref_rgb(200, 255, 255));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("mid_rst_sb_flush",  32'(sb.size()),     32'd0);
        bus.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        lat_chk = 1'b1;
        send(30, 128, 200, 204, ref_rgb(30, 128, 200));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/hsv_to_rgb_pipe.md
Name: hsv_to_rgb_pipe

Overview:
- Pipelined, parametrised HSV-to-RGB converter for the sprite colour-adjust path.
- Takes full H, S and V per pixel; S and V are no longer fixed at maximum.
- Carries a user sideband (e.g. pixel address) alongside each pixel.
- Emits packed RGB of configurable channel widths (default RGB565) over a valid/ready stream, so it can sit between the sprite ROM reader and the framebuffer writer.

Parameters:
- R_W, 5, red output width (1..8)
- G_W, 6, green output width (1..8)
- B_W, 5, blue output width (1..8)
- USER_W, 17, sideband width carried with each pixel (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input pixel valid
- in_ready  out  1  converter can accept a pixel this cycle
- in_h  in  8  hue, 0..255; 43 codes per sextant
- in_s  in  8  saturation
- in_v  in  8  value
- in_user  in  USER_W  sideband, passed through unchanged
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts
- out_rgb  out  R_W+G_W+B_W  packed {r,g,b}, red in MSBs
- out_user  out  USER_W  sideband aligned with out_rgb

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset).
- Reset values: out_valid=0, out_rgb=0, out_user=0, all internal stage-valid bits cleared. in_ready=1 in the cycle after reset.
- Pipeline: 3 register stages, latency exactly 3 cycles from input handshake to out_valid when never stalled; throughput 1 pixel/clk.
- Flow control:
  - advance = !out_valid || out_ready; in_ready = advance (combinational).
  - All stages move together when advance=1; a bubble entering shifts in with valid=0.
  - When advance=0, every stage holds and out_rgb/out_user stay stable while out_valid=1.
  - No pixel is dropped or duplicated.
- Stage 1 (sextant split):
  - region = in_h/43, range 0..5; h=255 gives region 5.
  - rem = (in_h - 43*region)*6, 8-bit, max 252.
  - Division is implemented as a threshold compare chain (43, 86, 129, 172, 215); no divider.
  - s, v and user are registered alongside.
- Stage 2 (intermediates), 16-bit products, truncate with >>8:
  - P = (v*(255-s))>>8
  - Q = (v*(255-((s*rem)>>8)))>>8
  - T = (v*(255-((s*(255-rem))>>8)))>>8
- Stage 3 (channel select), by region:
  - 0: (v,T,P); 1: (Q,v,P); 2: (P,v,T); 3: (P,Q,v); 4: (T,P,v); 5: (v,P,Q).
  - Override: if s==0 then r=g=b=v exactly (grey bypass; avoids the 255/256 loss in P).
- Quantisation of each 8-bit channel c to width W: c*(2^W-1)/255, truncating (integer divide).
- Reset asserted mid-stream discards all in-flight pixels; reset takes priority over advance.
- Simultaneous out_ready and in_valid with a full pipe: output drains and input enters in the same cycle.

Optional Feature:
- Macro: HSV_TO_RGB_ROUND_EN.
- Defined: quantisation rounds to nearest, (c*(2^W-1)+127)/255.
- Undefined: truncating divide as in Behaviour.
- Latency, handshake and all other behaviour are identical either way.

Decomposition:
- Shared package colour_pkg:
  - sextant constants (HUE_SEXTANT=43, REM_SCALE=6) and threshold list;
  - region enum/typedef (3 bits);
  - quantise function taking channel and width.
- One sub-module: hsv_stage_ctl, holding the per-stage valid bits and advance/in_ready logic. Datapath stays in the top module.

Test Plan:
- Primaries: h=0,s=255,v=255 -> 0xF800; h=86 -> 0x07E0; h=172 -> 0x001F; each appears exactly 3 cycles after input handshake with out_ready=1.
- Grey bypass: h=99,s=0,v=128 -> 0x7BEF (truncate) / 0x8410 (with HSV_TO_RGB_ROUND_EN); v=0 -> 0x0000.
- Sweep h=0..255 at s=255,v=255, back-to-back: 256 outputs in order, user tags 0..255 match, compared against a reference model; h=255 takes region 5, rem 240.
- Backpressure: stream 3 pixels, hold out_ready=0 for 5 cycles:
  - in_ready drops once the pipe is full;
  - out_rgb/out_user stay stable;
  - after release all 3 emerge in order with no loss.
- Random valid/ready toggling over 10k pixels: scoreboard shows zero loss, duplication or reordering.
- Reset with 3 pixels in flight:
  - out_valid=0 the cycle after reset;
  - no stale pixel emerges afterwards;
  - first post-reset pixel has 3-cycle latency.
